// File: rtl/stall_buffer_ctrl_if.sv
// stall_buffer_ctrl_if: upstream/downstream handshakes and stall-buffer command bundle
interface stall_buffer_ctrl_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              buf_enq;
  logic              buf_deq;
  logic              buf_flush;
  logic [DATA_W-1:0] buf_wdata;
  logic [DATA_W-1:0] buf_rdata;
  logic              buf_empty;
  logic              buf_full;
  modport master (
    input  in_valid, in_data, out_ready, buf_rdata, buf_empty, buf_full,
    output in_ready, out_valid, out_data, buf_enq, buf_deq, buf_flush, buf_wdata
  );
  modport slave (
    output in_valid, in_data, out_ready, buf_rdata, buf_empty, buf_full,
    input  in_ready, out_valid, out_data, buf_enq, buf_deq, buf_flush, buf_wdata
  );
endinterface

// File: rtl/stall_buffer_ctrl.sv
// stall_buffer_ctrl: sequences a 2-slot stall buffer between two pipeline stages
module stall_buffer_ctrl #(
  parameter int DATA_W        = 32,
  parameter int FLUSH_BUBBLE  = 2,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  stall_buffer_ctrl_if.master bus,
  output logic [15:0]         stall_count,
  output logic                stall_timeout,
  output logic                occ_err
);
  localparam int CW = STALL_TIMEOUT > 1 ? $clog2(STALL_TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {PASS, STALL, DRAIN, FLUSH} state_e;
  state_e            state_q, state_d;
  logic [3:0]        bubble_q, bubble_d;
  logic [1:0]        occ_q;
  logic [CW-1:0]     consec_q, consec_d;
  logic [15:0]       stall_cnt_q;
  logic              timeout_q, occ_err_q;
  logic              in_ready, out_valid, enq, deq, fl, stalled;
  logic [DATA_W-1:0] out_data;
  // handshake decode and next state; flush wins, reset forces every command low
  always_comb begin
    state_d   = state_q;
    bubble_d  = bubble_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = bus.buf_rdata;
    enq       = 1'b0;
    deq       = 1'b0;
    fl        = 1'b0;
    if (flush) begin
      fl       = 1'b1;
      state_d  = FLUSH_BUBBLE == 0 ? PASS : FLUSH;
      bubble_d = 4'(FLUSH_BUBBLE);
    end else begin
      case (state_q)
        PASS: begin
          in_ready  = 1'b1;
          out_valid = bus.in_valid;
          out_data  = bus.in_data;
          enq       = bus.in_valid & ~bus.out_ready;
          state_d   = enq ? STALL : PASS;
        end
        STALL: begin
          out_valid = 1'b1;
          deq       = bus.out_ready;
          in_ready  = ~bus.out_ready & ~bus.buf_full;
          enq       = in_ready & bus.in_valid;
          state_d   = bus.out_ready ? (occ_q == 2'd1 ? PASS : DRAIN) : STALL;
        end
        DRAIN: begin
          out_valid = 1'b1;
          deq       = bus.out_ready;
          state_d   = bus.out_ready ? (occ_q == 2'd1 ? PASS : DRAIN) : STALL;
        end
        default: begin
          bubble_d = bubble_q == 4'd0 ? 4'd0 : bubble_q - 4'd1;
          state_d  = bubble_q <= 4'd1 ? PASS : FLUSH;
        end
      endcase
    end
    if (reset) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      enq       = 1'b0;
      deq       = 1'b0;
      fl        = 1'b0;
    end
  end
  assign stalled  = out_valid & ~bus.out_ready;
  assign consec_d = stalled ? consec_q + CW'(consec_q != {CW{1'b1}}) : '0;
  // state, occupancy shadow and sticky monitors
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PASS;
      bubble_q    <= 4'd0;
      occ_q       <= 2'd0;
      consec_q    <= '0;
      stall_cnt_q <= 16'd0;
      timeout_q   <= 1'b0;
      occ_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bubble_q    <= bubble_d;
      occ_q       <= fl ? 2'd0 : occ_q + 2'(enq) - 2'(deq);
      consec_q    <= consec_d;
      stall_cnt_q <= stall_cnt_q + 16'(stalled && stall_cnt_q != 16'hFFFF);
      timeout_q   <= timeout_q | (STALL_TIMEOUT != 0 && consec_d == CW'(STALL_TIMEOUT));
      occ_err_q   <= occ_err_q | ((occ_q == 2'd0) != bus.buf_empty) | ((occ_q == 2'd2) != bus.buf_full);
    end
  end
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;
  assign bus.buf_enq    = enq;
  assign bus.buf_deq    = deq;
  assign bus.buf_flush  = fl;
  assign bus.buf_wdata  = bus.in_data;
  assign stall_count    = stall_cnt_q;
  assign stall_timeout  = timeout_q;
  assign occ_err        = occ_err_q;
endmodule

// File: tb/tb_stall_buffer_ctrl.sv
// tb_stall_buffer_ctrl: directed checks of bypass, stall, drain, flush, monitors and reset
module tb_stall_buffer_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        corrupt = 1'b0;
  logic [15:0] stall_count;
  logic        stall_timeout, occ_err;
  logic [31:0] mem [2];
  logic [1:0]  cnt;
  int          n_checks = 0;
  int          n_errs = 0;
  int          both_hits = 0;
  stall_buffer_ctrl_if #(.DATA_W(32)) bus();
  stall_buffer_ctrl #(.DATA_W(32), .FLUSH_BUBBLE(2), .STALL_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .stall_count(stall_count), .stall_timeout(stall_timeout), .occ_err(occ_err)
  );
  always #5 clk = ~clk;
  assign bus.buf_rdata = mem[0];
  assign bus.buf_empty = (cnt == 2'd0) ^ corrupt;
  assign bus.buf_full  = cnt == 2'd2;
  // 2-slot FIFO standing in for the real stall buffer
  always @(posedge clk) begin
    if (reset || bus.buf_flush) cnt <= 2'd0;
    else if (bus.buf_enq) begin
      mem[cnt[0]] <= bus.buf_wdata;
      cnt <= cnt + 2'd1;
    end else if (bus.buf_deq) begin
      mem[0] <= mem[1];
      cnt <= cnt - 2'd1;
    end
  end
  always @(negedge clk) if (bus.buf_enq && bus.buf_deq) both_hits++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    #3;
  endtask
  initial begin
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEAD_0000;
    bus.out_ready = 1'b1;
    #4;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_cmds", {bus.buf_enq, bus.buf_deq, bus.buf_flush}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #3;
    chk("post_rst_stall_count", stall_count, 0);
    chk("post_rst_flags", {stall_timeout, occ_err}, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'hA0 + 32'(i), 1'b1, 1'b0);
      chk("byp_valid", bus.out_valid, 1);
      chk("byp_data", bus.out_data, 32'hA0 + 32'(i));
      chk("byp_ready", bus.in_ready, 1);
      chk("byp_cmds", {bus.buf_enq, bus.buf_deq}, 0);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("byp_stall_count", stall_count, 0);
    step(1'b1, 32'h11, 1'b0, 1'b0);
    chk("fill1_data", bus.out_data, 32'h11);
    chk("fill1_enq", bus.buf_enq, 1);
    chk("fill1_ready", bus.in_ready, 1);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    chk("fill2_data", bus.out_data, 32'h11);
    chk("fill2_enq", bus.buf_enq, 1);
    chk("fill2_ready", bus.in_ready, 1);
    step(1'b1, 32'h33, 1'b0, 1'b0);
    chk("full_ready", bus.in_ready, 0);
    chk("full_enq", bus.buf_enq, 0);
    chk("full_data", bus.out_data, 32'h11);
    step(1'b1, 32'h33, 1'b0, 1'b0);
    chk("fill_stall_count", stall_count, 3);
    step(1'b1, 32'h33, 1'b1, 1'b0);
    chk("drain1_data", bus.out_data, 32'h11);
    chk("drain1_deq", bus.buf_deq, 1);
    chk("drain1_ready", bus.in_ready, 0);
    step(1'b1, 32'h33, 1'b1, 1'b0);
    chk("drain2_data", bus.out_data, 32'h22);
    chk("drain2_deq", bus.buf_deq, 1);
    chk("drain2_ready", bus.in_ready, 0);
    step(1'b1, 32'h33, 1'b1, 1'b0);
    chk("after_drain_data", bus.out_data, 32'h33);
    chk("after_drain_ready", bus.in_ready, 1);
    chk("after_drain_enq", bus.buf_enq, 0);
    chk("drain_stall_count", stall_count, 4);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h44, 1'b0, 1'b0);
    step(1'b1, 32'h55, 1'b0, 1'b0);
    step(1'b1, 32'h66, 1'b1, 1'b1);
    chk("flush_pulse", bus.buf_flush, 1);
    chk("flush_hs", {bus.out_valid, bus.in_ready}, 0);
    chk("flush_cmds", {bus.buf_enq, bus.buf_deq}, 0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'h66, 1'b1, 1'b0);
      chk("bubble_hs", {bus.out_valid, bus.in_ready}, 0);
      chk("bubble_cmds", {bus.buf_enq, bus.buf_deq, bus.buf_flush}, 0);
    end
    step(1'b1, 32'h66, 1'b1, 1'b0);
    chk("post_flush_ready", bus.in_ready, 1);
    chk("post_flush_data", bus.out_data, 32'h66);
    chk("post_flush_empty", bus.buf_empty, 1);
    chk("flush_stall_count", stall_count, 6);
    chk("flush_occ_err", occ_err, 0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h77, 1'b0, 1'b0);
      chk($sformatf("timeout_c%0d", i), stall_timeout, 32'(i >= 8));
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("timeout_stall_count", stall_count, 16);
    chk("timeout_deq", bus.buf_deq, 1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("timeout_sticky", stall_timeout, 1);
    chk("drained_hs", {bus.out_valid, bus.in_ready}, 32'b01);
    chk("pre_corrupt_occ_err", occ_err, 0);
    corrupt = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("occ_err_set", occ_err, 1);
    corrupt = 1'b0;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("occ_err_sticky", occ_err, 1);
    step(1'b1, 32'h88, 1'b0, 1'b0);
    step(1'b1, 32'h99, 1'b0, 1'b0);
    step(1'b1, 32'hAA, 1'b0, 1'b0);
    chk("pre_rst_full", bus.buf_full, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    #3;
    chk("midrst_hs", {bus.out_valid, bus.in_ready}, 0);
    chk("midrst_cmds", {bus.buf_enq, bus.buf_deq, bus.buf_flush}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #3;
    chk("midrst_pass_hs", {bus.out_valid, bus.in_ready}, 32'b01);
    chk("midrst_stall_count", stall_count, 0);
    chk("midrst_flags", {stall_timeout, occ_err}, 0);
    step(1'b1, 32'hBB, 1'b1, 1'b0);
    chk("midrst_bypass", bus.out_data, 32'hBB);
    chk("midrst_occ_err", occ_err, 0);
    chk("enq_deq_overlap", both_hits, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/stall_buffer_ctrl.md
Name: stall_buffer_ctrl

Overview:
- Controller that sequences the 2-slot stall buffer (enq/deq/flush, 32-bit data, empty/full flags) between two pipeline stages.
- Converts the upstream and downstream valid/ready handshakes into buffer commands.
- Provides bypass when the buffer is empty and an occupancy shadow that cross-checks the buffer flags.
- Performs flush sequencing with a recovery bubble, and keeps stall performance and timeout monitoring.

Parameters:
- DATA_W, 32, width of the data path; must equal the buffer width.
- FLUSH_BUBBLE, 2, cycles after a flush cycle during which in_ready=0 and out_valid=0; legal range 0..15.
- STALL_TIMEOUT, 1024, consecutive stalled cycles that set stall_timeout; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush request (e.g. redirect).
- in_valid  in  1  upstream data valid.
- in_data  in  DATA_W  upstream data.
- in_ready  out  1  controller accepts in_data this cycle.
- out_valid  out  1  downstream data valid.
- out_data  out  DATA_W  downstream data.
- out_ready  in  1  downstream accepts out_data.
- buf_enq  out  1  buffer enqueue.
- buf_deq  out  1  buffer dequeue.
- buf_flush  out  1  buffer flush.
- buf_wdata  out  DATA_W  buffer write data; always equals in_data.
- buf_rdata  in  DATA_W  buffer head (slot 0).
- buf_empty  in  1  buffer empty flag.
- buf_full  in  1  buffer full flag.
- stall_count  out  16  total cycles with out_valid=1 and out_ready=0; saturates at 16'hFFFF.
- stall_timeout  out  1  sticky; set when the consecutive-stall counter reaches STALL_TIMEOUT.
- occ_err  out  1  sticky; the occupancy shadow disagrees with buf_empty/buf_full.

Behaviour:
- Reset (reset=1 at a clk edge): state=PASS, occ=0, bubble counter=0, consecutive-stall counter=0, stall_count=0, stall_timeout=0, occ_err=0.
- While reset is high, all outputs are forced low: in_ready, out_valid, buf_enq, buf_deq, buf_flush.
- Reset mid-operation discards buffered data and does not pulse buf_flush.
- Buffer commands are one-hot: buf_enq, buf_deq and buf_flush are never high in the same cycle. The buffer gives enq priority over deq, so simultaneous enq and deq are forbidden.
- occ (0..2) is updated on the clock edge: +1 on buf_enq, -1 on buf_deq, 0 on buf_flush.
- Every cycle, occ_err is set if (occ==0)!=buf_empty or (occ==2)!=buf_full.
- State PASS (occ=0):
  - out_valid=in_valid, out_data=in_data, in_ready=1. Zero-latency bypass.
  - in_valid & !out_ready: buf_enq=1, go to STALL.
- State STALL (occ>=1):
  - out_valid=1, out_data=buf_rdata.
  - If out_ready: buf_deq=1 and in_ready=0. Go to PASS if occ==1, else to DRAIN.
  - Else: in_ready=!buf_full. If in_valid & !buf_full: buf_enq=1, stay in STALL.
- State DRAIN (occ>=1):
  - out_valid=1, out_data=buf_rdata, in_ready=0. Upstream is held so buffered order is preserved.
  - out_ready: buf_deq=1; go to PASS when occ becomes 0.
  - !out_ready: go to STALL.
- Flush: flush=1 in any state takes priority over all of the above.
  - That cycle: buf_flush=1, in_ready=0, out_valid=0, no enq or deq.
  - Next state FLUSH with bubble=FLUSH_BUBBLE.
- State FLUSH:
  - in_ready=0, out_valid=0.
  - bubble decrements each cycle; go to PASS when bubble==0. FLUSH_BUBBLE=0 returns to PASS on the cycle after the flush cycle.
  - flush re-asserted in FLUSH pulses buf_flush again and reloads bubble.
- Ordering: data leaves in acceptance order; there is no loss and no duplication outside a flush.
- Stall monitor:
  - Consecutive-stall counter increments while out_valid & !out_ready, clears otherwise, and saturates.
  - stall_timeout is set when the counter equals STALL_TIMEOUT; it clears only on reset.
- stall_count does not increment in FLUSH (out_valid=0 there).

Test Plan:
- Bypass: out_ready=1; stream A0..A3 with in_valid=1 → out_data equals in_data in the same cycle; buf_enq and buf_deq never high; stall_count=0.
- Stall fill: send 0x11, 0x22, 0x33 with out_ready=0 → 0x11 and 0x22 enqueued; in_ready=0 once buf_full; 0x33 held upstream; stall_count increments each cycle.
- Drain order: from the full buffer, raise out_ready → out_data 0x11 then 0x22 on consecutive cycles; in_ready=0 in both; PASS follows; 0x33 is then bypassed.
- Flush: with the buffer full, assert flush for 1 cycle (FLUSH_BUBBLE=2) → buf_flush pulses once; out_valid=0 and in_ready=0 for 3 cycles in total; then in_ready=1; the old data is never presented.
- Timeout and sticky flags: STALL_TIMEOUT=8 with out_ready=0 for 10 cycles → stall_timeout set at the 8th stalled cycle and remains set. Forcing buf_empty=0 while occ=0 → occ_err=1.
- Reset mid-stall: with occ=2, assert reset for 1 cycle → all outputs low during reset; state PASS, all counters and flags at 0 afterward; no buf_flush pulse.
